// File: rtl/dreg_load_arbiter_if.sv
// Requester-side and register-bank-side signals of the DReg load arbiter.
// The master modport is the requester/bank environment; the slave modport
// is the arbiter itself.
interface dreg_load_arbiter_if #(
    parameter int NREQ = 3,
    parameter int NREG = 4,
    parameter int DW   = 4,
    parameter int AW   = (NREG > 1) ? $clog2(NREG) : 1
);
    logic                 en;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      ack;
    logic [NREG-1:0]      ld;
    logic [DW-1:0]        d_out;
    logic                 busy;

    modport master (
        output en,
        output req,
        output req_addr,
        output req_data,
        input  ack,
        input  ld,
        input  d_out,
        input  busy
    );

    modport slave (
        input  en,
        input  req,
        input  req_addr,
        input  req_data,
        output ack,
        output ld,
        output d_out,
        output busy
    );
endinterface

// File: rtl/dreg_load_arbiter.sv
// Round-robin write arbiter and load sequencer for a bank of DReg digit
// registers. One requester is granted per cycle; the grant drives a one-hot
// load strobe, the shared data bus and an ack pulse back to the winner.
// The requester acked in the previous cycle is masked so a held request is
// never granted twice for the same write. All outputs are registered.
module dreg_load_arbiter #(
    parameter int NREQ = 3,
    parameter int NREG = 4,
    parameter int DW   = 4,
    parameter int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    dreg_load_arbiter_if.slave  bus
);

    localparam int PW = $clog2(NREQ);

    // Decode a register address into a one-hot load strobe; addresses at or
    // beyond NREG produce no strobe at all.
    function automatic logic [NREG-1:0] addr_to_onehot(input logic [AW-1:0] addr);
        logic [NREG-1:0] oh;
        oh = '0;
        for (int r = 0; r < NREG; r++) begin
            if (int'(addr) == r) begin
                oh[r] = 1'b1;
            end else begin
                oh[r] = 1'b0;
            end
        end
        return oh;
    endfunction

    // Registered state
    logic [NREQ-1:0] ack_q,   ack_d;
    logic [NREG-1:0] ld_q,    ld_d;
    logic [DW-1:0]   d_out_q, d_out_d;
    logic            busy_q,  busy_d;
    logic [PW-1:0]   ptr_q,   ptr_d;

    // Arbitration intermediates
    logic [NREQ-1:0] ack_mask_s;
    logic [NREQ-1:0] elig_s;
    logic            found_s;
    logic [PW-1:0]   win_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_data_s;

    // Eligible requesters: everyone asking except last cycle's winner.
    always_comb begin
        ack_mask_s = ack_q;
        elig_s     = bus.req & ~ack_mask_s;
    end

    // Round-robin search upward from ptr, wrapping modulo NREQ.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        if (bus.en) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!found_s && elig_s[(int'(ptr_q) + k) % NREQ]) begin
                    found_s = 1'b1;
                    win_s   = PW'((int'(ptr_q) + k) % NREQ);
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            found_s = 1'b0;
        end
    end

    // Only the winner's address and data are routed onward.
    always_comb begin
        sel_addr_s = bus.req_addr[int'(win_s)*AW +: AW];
        sel_data_s = bus.req_data[int'(win_s)*DW +: DW];
    end

    // Next grant: strobe, data and ack for a winner, otherwise idle with
    // d_out and ptr held.
    always_comb begin
        ack_d   = '0;
        ld_d    = '0;
        d_out_d = d_out_q;
        ptr_d   = ptr_q;
        if (found_s) begin
            ack_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
            ld_d    = addr_to_onehot(sel_addr_s);
            d_out_d = sel_data_s;
            if (int'(win_s) == NREQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_s + {{(PW-1){1'b0}}, 1'b1};
            end
        end else begin
            ack_d   = '0;
            ld_d    = '0;
            d_out_d = d_out_q;
            ptr_d   = ptr_q;
        end
        busy_d = (|ld_d) | (|ack_d);
    end

    // Grant register; reset abandons any in-flight write without an ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= '0;
            ld_q    <= '0;
            d_out_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
        end else begin
            ack_q   <= ack_d;
            ld_q    <= ld_d;
            d_out_q <= d_out_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.ld    = ld_q;
    assign bus.d_out = d_out_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_dreg_load_arbiter.sv
// Scoreboard bench for dreg_load_arbiter: directed stimulus pushes the
// hand-computed grant it expects; a monitor pops and compares on every
// cycle the DUT shows activity.
module tb_dreg_load_arbiter;

    localparam int NREQ = 3;
    localparam int NREG = 4;
    localparam int DW   = 4;
    localparam int AW   = 2;

    typedef struct packed {
        logic [NREQ-1:0] ack;
        logic [NREG-1:0] ld;
        logic [DW-1:0]   d;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;
    logic [DW-1:0] bank [NREG];

    dreg_load_arbiter_if #(.NREQ(NREQ), .NREG(NREG), .DW(DW), .AW(AW)) bus ();

    dreg_load_arbiter #(.NREQ(NREQ), .NREG(NREG), .DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [NREQ-1:0] a, input logic [NREG-1:0] l, input logic [DW-1:0] d);
        exp_t e;
        e.ack = a;
        e.ld  = l;
        e.d   = d;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
        bus.req[i]               = 1'b1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (bus.busy || bus.ack != '0 || bus.ld != '0)) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_grant actual ack=%b ld=%b d=%h busy=%b required=none at %0t",
                             bus.ack, bus.ld, bus.d_out, bus.busy, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.ack !== e.ack || bus.ld !== e.ld || bus.d_out !== e.d || bus.busy !== 1'b1) begin
                        n_bad++;
                        $display("FAIL grant actual ack=%b ld=%b d=%h busy=%b required ack=%b ld=%b d=%h busy=1 at %0t",
                                 bus.ack, bus.ld, bus.d_out, bus.busy, e.ack, e.ld, e.d, $time);
                    end
                end
                for (int r = 0; r < NREG; r++) begin
                    if (bus.ld[r]) bank[r] = bus.d_out;
                end
            end
        end
    endtask

    initial begin
        int cnt [NREQ];
        n_cmp        = 0;
        n_bad        = 0;
        rst_n        = 1'b0;
        bus.en       = 1'b1;
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        for (int r = 0; r < NREG; r++) bank[r] = '0;

        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog actual=timeout required=finish");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset / idle
        repeat (3) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_ack",  32'(bus.ack),   32'd0);
            chk("idle_ld",   32'(bus.ld),    32'd0);
            chk("idle_dout", 32'(bus.d_out), 32'd0);
            chk("idle_busy", 32'(bus.busy),  32'd0);
            chk("idle_ptr",  32'(dut.ptr_q), 32'd0);
        end

        // Single write: requester 1, addr 2, data A
        push(3'b010, 4'b0100, 4'hA);
        set_req(1, 2'd2, 4'hA);
        tick();
        chk("single_ack", 32'(bus.ack), 32'h2);
        bus.req = '0;
        tick();
        chk("single_ack_clear", 32'(bus.ack), 32'd0);

        // Round-robin from ptr=0, each requester writes twice
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        push(3'b001, 4'b0001, 4'h1);
        push(3'b010, 4'b0010, 4'h2);
        push(3'b100, 4'b1000, 4'h3);
        push(3'b001, 4'b0001, 4'h1);
        push(3'b010, 4'b0010, 4'h2);
        push(3'b100, 4'b1000, 4'h3);
        set_req(0, 2'd0, 4'h1);
        set_req(1, 2'd1, 4'h2);
        set_req(2, 2'd3, 4'h3);
        for (int i = 0; i < NREQ; i++) cnt[i] = 2;
        for (int c = 0; c < 20 && bus.req != '0; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (bus.ack[i]) begin
                    cnt[i]--;
                    if (cnt[i] == 0) bus.req[i] = 1'b0;
                end
            end
        end
        chk("rr_done", 32'(bus.req), 32'd0);
        tick();
        chk("bank0", 32'(bank[0]), 32'h1);
        chk("bank1", 32'(bank[1]), 32'h2);
        chk("bank3", 32'(bank[3]), 32'h3);

        // Hold-after-ack masking: requester 0 alone for 4 cycles
        push(3'b001, 4'b0010, 4'h5);
        push(3'b001, 4'b0010, 4'h5);
        set_req(0, 2'd1, 4'h5);
        tick();
        chk("mask_c1", 32'(bus.ack), 32'h1);
        tick();
        chk("mask_c2", 32'(bus.ack), 32'h0);
        tick();
        chk("mask_c3", 32'(bus.ack), 32'h1);
        tick();
        chk("mask_c4", 32'(bus.ack), 32'h0);
        bus.req = '0;
        tick();

        // Enable gating
        bus.en = 1'b0;
        set_req(2, 2'd2, 4'h7);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("en_off_ack", 32'(bus.ack), 32'd0);
        end
        push(3'b100, 4'b0100, 4'h7);
        bus.en = 1'b1;
        tick();
        chk("en_on_ack", 32'(bus.ack), 32'h4);
        bus.en  = 1'b0;
        bus.req = '0;
        set_req(0, 2'd1, 4'h9);
        tick();
        chk("en_pending_ack", 32'(bus.ack), 32'd0);
        tick();
        chk("en_pending_ack2", 32'(bus.ack), 32'd0);
        push(3'b001, 4'b0010, 4'h9);
        bus.en = 1'b1;
        tick();
        chk("en_resume_ack", 32'(bus.ack), 32'h1);
        bus.req = '0;
        tick();

        // Async reset mid-grant
        set_req(1, 2'd0, 4'hC);
        tick();
        chk("rst_pre_ld", 32'(bus.ld), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_ld",   32'(bus.ld),    32'd0);
        chk("rst_ack",  32'(bus.ack),   32'd0);
        chk("rst_dout", 32'(bus.d_out), 32'd0);
        chk("rst_busy", 32'(bus.busy),  32'd0);
        chk("rst_ptr",  32'(dut.ptr_q), 32'd0);
        tick();
        rst_n = 1'b1;
        push(3'b010, 4'b0001, 4'hC);
        tick();
        chk("regrant_ack", 32'(bus.ack), 32'h2);
        chk("regrant_ptr", 32'(dut.ptr_q), 32'h2);
        bus.req = '0;
        repeat (3) tick();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dreg_load_arbiter.md
# dreg_load_arbiter

Round-robin write arbiter and load sequencer for the peripheral's bank of 4-bit `DReg` digit registers. Several requesters (MCU output-port decode, keypad scanner, debug loader) each present a register address and nibble. The block grants one requester per cycle and drives the one-hot `ld` strobes and shared data bus of the register bank. It sits between the requester logic and the `DReg` instances in the peripheral.

## Interface
Parameters:
- `NREQ`, 3: number of requesters (2..8).
- `NREG`, 4: number of `DReg` targets (1..16).
- `DW`, 4: data width, equal to the `DReg` width.
- `AW`, `$clog2(NREG)` (minimum 1): address width per requester.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  arbitration enable; when low, no new grants are issued.
- `req`  in  NREQ  per-requester write request (level).
- `req_addr`  in  NREQ*AW  packed target addresses; requester i occupies `[i*AW +: AW]`.
- `req_data`  in  NREQ*DW  packed write data; requester i occupies `[i*DW +: DW]`.
- `ack`  out  NREQ  one-cycle pulse to the granted requester.
- `ld`  out  NREG  one-hot load strobes to the `DReg` bank.
- `d_out`  out  DW  write data to every `DReg` `dIn`.
- `busy`  out  1  high in any cycle in which `ld` or `ack` is nonzero.

## Operation
- Arbitration stage (combinational, evaluated in cycle N):
  - Eligible set = `req & ~ack_mask`. `ack_mask` is the requester granted in cycle N-1 (equal to the current `ack`).
  - The winner is the first eligible index found by searching upward from `ptr`, wrapping modulo NREQ.
  - No winner is selected when `en`=0 or the eligible set is empty.
- Grant register (edge ending cycle N):
  - For a winner w, the block registers `ack[w]`=1, `d_out`=`req_data[w]`, and `ld` = one-hot(`req_addr[w]`).
  - `ptr` <= (w+1) mod NREQ.
  - With no winner: `ack`, `ld` <= 0, `d_out` holds its previous value, and `ptr` is unchanged.
- Out-of-range address (`req_addr` >= NREG): the request is granted and acked normally, `ld` stays all-zero, and `d_out` is updated.
- Requester protocol:
  - Hold `req`, `req_addr`, `req_data` stable from assertion until the cycle in which `ack` is seen high.
  - On the cycle after `ack`, either drop `req` or present the next write.
  - The masking rule guarantees that a held request is never granted twice for the same write.
- `en` falling: a grant already registered still completes (its `ld`/`ack` cycle occurs). Pending requests wait; they are not dropped.
- Reset (asserted asynchronously, including mid-grant):
  - `ack`=0, `ld`=0, `d_out`=0, `busy`=0, `ptr`=0, `ack_mask`=0 immediately.
  - An in-flight write is lost without `ack`. Requesters retry after reset.
- Sampling: the block never samples `req_*` inputs of non-winners. `DReg` loads on the same edge that the block samples the next arbitration.

## Timing
- Latency: `req` is first seen high in cycle N with no competition, so `ld`/`ack`/`d_out` are valid in cycle N+1, and the `DReg` captures on the edge ending N+1.
- Throughput: 1 write per cycle aggregate. A single requester is limited to 1 write every 2 cycles by masking.
- Simultaneous requests: all NREQ requesters asserting together are served in rotating order starting at `ptr`. Each is acked within NREQ+1 cycles (starvation bound).
- Two requesters targeting the same register in consecutive grants: both writes occur in grant order, and the later write's data persists.
- `busy` is a registered output: `busy` = |`ld` | |`ack`.
- All outputs are registered; the block has no combinational path from inputs to outputs.

## Test plan
- Reset/idle: hold `rst_n`=0 then release, with `req`=0. Required: all outputs 0 for 10 cycles and `ptr` stays 0.
- Single write: requester 1 issues addr=2, data=0xA in cycle 5. Required: in cycle 6 `ack`=3'b010, `ld`=4'b0100, `d_out`=0xA, `busy`=1; in cycle 7 `ack`=0.
- Round-robin: all three requesters hold `req` with addrs 0/1/3 and data 0x1/0x2/0x3. Required: grant order 0,1,2,0… from `ptr`=0. Each requester's `ack` arrives at most every 3 cycles with no double ack per write. The bank ends at 0x1/0x2/–/0x3.
- Hold-after-ack masking: requester 0 keeps `req` high for 4 cycles alone. Required: `ack[0]` pulses on alternate cycles only.
- Enable gating: assert `req[2]` while `en`=0 for 5 cycles. Required: no `ack`. Raise `en`; required: `ack[2]` one cycle later. Lowering `en` in the grant cycle still completes that grant.
- Async reset mid-grant: assert `rst_n` low in the middle of a cycle in which `ld`=4'b0001. Required: `ld`, `ack`, `d_out` go to 0 before the next edge. After release with the same request still pending, it is re-granted with `ptr` restarting at 0.
